// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the write-back pipeline stage register.
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default widths of the write-back fields.
//   wb_payload_t                    : write-back record (wb_en, wb_addr, wb_data) at the
//                                     default widths. Modules with other widths declare
//                                     the same record locally from their own parameters.
package pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    typedef struct packed {
        logic                      wb_en;
        logic [DEFAULT_ADDR_W-1:0] wb_addr;
        logic [DEFAULT_DATA_W-1:0] wb_data;
    } wb_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot -- one storage slot of the pipeline stage: a valid flag plus a payload register.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; clears valid and payload
//   i_load   : capture i_data and mark the slot valid
//   i_clear  : invalidate the slot (wins over i_load); payload is left as is
//   i_data   : payload to capture
//   o_valid  : slot holds an entry
//   o_data   : stored payload
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(wb_payload_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register for a write-back payload.
//
// Build option: define PIPE_STAGE_SKID_EN for the two-slot (main + skid) variant with a
// registered in_ready. Without it the stage has the main slot only and in_ready is
// combinational: (NOT out_valid) OR out_ready.
//
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   flush           : drop every held entry and the input presented this cycle
//   in_valid/ready  : upstream handshake
//   in_wb_*         : incoming write-back enable, address, data
//   out_valid/ready : downstream handshake
//   out_wb_*        : outgoing write-back enable, address, data (driven by the main slot)
//   occupancy       : number of held entries
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic [ADDR_W-1:0] in_wb_addr,
    input  logic [DATA_W-1:0] in_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic [ADDR_W-1:0] out_wb_addr,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              wb_en;
        logic [ADDR_W-1:0] wb_addr;
        logic [DATA_W-1:0] wb_data;
    } payload_t;

    localparam int unsigned PAYLOAD_W = $bits(payload_t);

    payload_t w_in_payload;
    payload_t w_main_d;
    payload_t w_main_payload;
    logic     w_main_valid;
    logic     w_in_fire;
    logic     w_out_fire;
    logic     w_main_free;
    logic     w_main_load;
    logic     w_main_clear;

    assign w_in_payload = '{wb_en: in_wb_en, wb_addr: in_wb_addr, wb_data: in_wb_data};
    assign w_in_fire    = in_valid & in_ready;
    assign w_out_fire   = w_main_valid & out_ready;
    // Main can take a new entry this edge if it is empty or its entry leaves now.
    assign w_main_free  = ~w_main_valid | w_out_fire;
    // A departing entry without a replacement empties main; flush always does.
    assign w_main_clear = flush | (w_out_fire & ~w_main_load);

`ifdef PIPE_STAGE_SKID_EN
    payload_t w_skid_payload;
    logic     w_skid_valid;
    logic     w_skid_load;
    logic     w_skid_clear;
    logic     w_skid_valid_d;
    logic     r_in_ready;

    // Skid is older than any input, so it refills main first.
    assign w_main_load    = ~flush & w_main_free & (w_skid_valid | w_in_fire);
    assign w_main_d       = w_skid_valid ? w_skid_payload : w_in_payload;

    assign w_skid_load    = ~flush & w_in_fire & ~w_main_free;
    assign w_skid_clear   = flush | (w_skid_valid & w_main_free);
    assign w_skid_valid_d = w_skid_load | (w_skid_valid & ~w_skid_clear);

    // in_ready tracks the skid slot's next state so it never depends on out_ready
    // combinationally; an accepted input always has room in main or skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= ~w_skid_valid_d;
        end
    end

    pipe_slot #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_payload)
    );

    assign in_ready  = r_in_ready;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
`else
    // An accepted input implies main is free, so no extra qualification is needed.
    assign w_main_load = ~flush & w_in_fire;
    assign w_main_d    = w_in_payload;
    assign in_ready    = ~rst & w_main_free;
    assign occupancy   = {1'b0, w_main_valid};
`endif

    pipe_slot #(
        .WIDTH (PAYLOAD_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_payload)
    );

    assign out_valid   = w_main_valid;
    assign out_wb_en   = w_main_valid & w_main_payload.wb_en;
    assign out_wb_addr = w_main_payload.wb_addr;
    assign out_wb_data = w_main_payload.wb_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- directed vectors plus a randomised handshake run for pipe_stage_reg.
// Expectations adapt to PIPE_STAGE_SKID_EN (maximum occupancy 2 with it, 1 without).
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef PIPE_STAGE_SKID_EN
    localparam int MAX_OCC = 2;
`else
    localparam int MAX_OCC = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_wb_en;
    logic [ADDR_W-1:0] in_wb_addr;
    logic [DATA_W-1:0] in_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_wb_en;
    logic [ADDR_W-1:0] out_wb_addr;
    logic [DATA_W-1:0] out_wb_data;
    logic [1:0]        occupancy;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wb_en    (in_wb_en),
        .in_wb_addr  (in_wb_addr),
        .in_wb_data  (in_wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wb_en   (out_wb_en),
        .out_wb_addr (out_wb_addr),
        .out_wb_data (out_wb_data),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic en, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        in_valid   = v;
        in_wb_en   = en;
        in_wb_addr = a;
        in_wb_data = d;
    endtask

    // Scoreboard: entries accepted in order, popped on every downstream transfer.
    logic [37:0] sb_q[$];
    logic        prev_stall = 1'b0;
    logic [37:0] prev_out;
    logic [37:0] exp_pl;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", 64'(out_valid), 64'd1);
                check_eq("hold_payload", 64'({out_wb_en, out_wb_addr, out_wb_data}),
                         64'(prev_out));
            end
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 64'(sb_q.size() == 0), 64'd0);
                if (sb_q.size() != 0) begin
                    exp_pl = sb_q.pop_front();
                    check_eq("sb_order", 64'({out_wb_en, out_wb_addr, out_wb_data}),
                             64'(exp_pl));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back({in_wb_en, in_wb_addr, in_wb_data});
            end
            prev_stall = out_valid & ~out_ready & ~flush;
            prev_out   = {out_wb_en, out_wb_addr, out_wb_data};
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, 1'b0, '0, '0);

        // Reset state
        step();
        step();
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_wb_en", 64'(out_wb_en), 64'd0);
        rst = 1'b0;
        step();
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single entry, empty stage: visible one cycle after acceptance
        out_ready = 1'b1;
        drive_in(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        step();
        drive_in(1'b0, 1'b0, '0, '0);
        check_eq("t1_valid", 64'(out_valid), 64'd1);
        check_eq("t1_addr", 64'(out_wb_addr), 64'd3);
        check_eq("t1_data", 64'(out_wb_data), 64'hDEAD_BEEF);
        check_eq("t1_wb_en", 64'(out_wb_en), 64'd1);
        check_eq("t1_occ", 64'(occupancy), 64'd1);
        step();
        check_eq("t1_drained", 64'(out_valid), 64'd0);
        check_eq("t1_occ0", 64'(occupancy), 64'd0);

        // Backpressure: A then B with out_ready low, then drain back to back
        out_ready = 1'b0;
        drive_in(1'b1, 1'b1, 5'd1, 32'h1);
        step();
        drive_in(1'b1, 1'b1, 5'd2, 32'h2);
        step();
        check_eq("t2_occ_full", 64'(occupancy), 64'(MAX_OCC));
        check_eq("t2_in_ready", 64'(in_ready), 64'd0);
        check_eq("t2_out_a", 64'(out_wb_data), 64'h1);
        out_ready = 1'b1;
        step();
        drive_in(1'b0, 1'b0, '0, '0);
        check_eq("t2_valid_b", 64'(out_valid), 64'd1);
        check_eq("t2_out_b", 64'(out_wb_data), 64'h2);
        check_eq("t2_addr_b", 64'(out_wb_addr), 64'd2);
        check_eq("t2_occ_b", 64'(occupancy), 64'd1);
        check_eq("t2_in_ready_b", 64'(in_ready), 64'd1);
        step();
        check_eq("t2_drained", 64'(out_valid), 64'd0);

        // Flush with the stage full and a new input presented
        out_ready = 1'b0;
        drive_in(1'b1, 1'b1, 5'd4, 32'h3);
        step();
        drive_in(1'b1, 1'b1, 5'd5, 32'h4);
        step();
        check_eq("t3_occ_full", 64'(occupancy), 64'(MAX_OCC));
        drive_in(1'b1, 1'b1, 5'd6, 32'h5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_in(1'b0, 1'b0, '0, '0);
        check_eq("t3_valid", 64'(out_valid), 64'd0);
        check_eq("t3_occ", 64'(occupancy), 64'd0);
        check_eq("t3_idle_wb_en", 64'(out_wb_en), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        check_eq("t3_no_ghost", 64'(out_valid), 64'd0);

        // Flush beats acceptance on an empty stage
        drive_in(1'b1, 1'b1, 5'd7, 32'h66);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_in(1'b0, 1'b0, '0, '0);
        check_eq("t3b_valid", 64'(out_valid), 64'd0);
        check_eq("t3b_occ", 64'(occupancy), 64'd0);

        // Entry with write enable low
        out_ready = 1'b0;
        drive_in(1'b1, 1'b0, 5'd7, 32'h55);
        step();
        drive_in(1'b0, 1'b0, '0, '0);
        check_eq("t4_valid", 64'(out_valid), 64'd1);
        check_eq("t4_wb_en", 64'(out_wb_en), 64'd0);
        check_eq("t4_data", 64'(out_wb_data), 64'h55);
        out_ready = 1'b1;
        step();
        check_eq("t4_drained", 64'(out_valid), 64'd0);

        // Reset mid-stream with the stage full
        out_ready = 1'b0;
        drive_in(1'b1, 1'b1, 5'd9, 32'h7);
        step();
        drive_in(1'b1, 1'b1, 5'd10, 32'h8);
        step();
        check_eq("t5_occ_full", 64'(occupancy), 64'(MAX_OCC));
        drive_in(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        step();
        check_eq("t5_valid", 64'(out_valid), 64'd0);
        check_eq("t5_occ", 64'(occupancy), 64'd0);
        check_eq("t5_wb_en", 64'(out_wb_en), 64'd0);
        check_eq("t5_addr", 64'(out_wb_addr), 64'd0);
        check_eq("t5_data", 64'(out_wb_data), 64'd0);
        check_eq("t5_in_ready_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        step();
        check_eq("t5_in_ready_after", 64'(in_ready), 64'd1);
        check_eq("t5_valid_after", 64'(out_valid), 64'd0);

        // Random handshakes with occasional flush; the scoreboard checks every transfer
        for (int i = 0; i < 10000; i++) begin
            drive_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ADDR_W'($urandom()), $urandom());
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        drive_in(1'b0, 1'b0, '0, '0);
        step();
        step();
        step();
        check_eq("final_occ", 64'(occupancy), 64'd0);
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
